// File: rtl/seq_alu_pkg.sv
// ============================================================================
// Module   : seq_alu_pkg
// Brief    : Shared opcodes, FSM state encoding and default width for seq_alu.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seq_alu_pkg;

    localparam int c_default_xlen = 64;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SLL  = 4'b0101,
        OP_SRL  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_SLT  = 4'b1000,
        OP_SLTU = 4'b1001,
        OP_MUL  = 4'b1010,
        OP_MULH = 4'b1011,
        OP_DIV  = 4'b1100,
        OP_DIVU = 4'b1101,
        OP_REM  = 4'b1110,
        OP_REMU = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_alu_muldiv.sv
// ============================================================================
// Module   : seq_alu_muldiv
// Brief    : Iterative shift-add multiplier / restoring divider, one bit per
//            cycle, working on magnitudes with a final sign fix-up.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_alu_muldiv #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int                 c_cnt_w = $clog2(XLEN);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(XLEN - 1);

    // op[2]: divide family; op[0] on a divide selects unsigned
    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_trial;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;

    logic               r_busy;
    logic               r_done;
    logic [c_cnt_w-1:0] r_count;
    logic [2:0]         r_op;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2*XLEN-1:0]  r_prod;
    logic [2*XLEN-1:0]  r_mcand;
    logic [XLEN-1:0]    r_mplier;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_quo;
    logic [XLEN-1:0]    r_dvsr;

    assign w_signed = !(op[2] && op[0]);
    assign w_a_neg  = w_signed && a[XLEN-1];
    assign w_b_neg  = w_signed && b[XLEN-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    assign w_shift  = {r_rem, r_quo[XLEN-1]};
    assign w_trial  = w_shift - {1'b0, r_dvsr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_count  <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_busy   <= 1'b1;
                r_count  <= '0;
                r_op     <= op;
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_prod   <= '0;
                r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
                r_mplier <= w_b_mag;
                r_rem    <= '0;
                r_quo    <= w_a_mag;
                r_dvsr   <= w_b_mag;
            end else if (r_busy) begin
                // Both datapaths step together; the output mux picks one
                if (r_mplier[0]) begin
                    r_prod <= r_prod + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                if (!w_trial[XLEN]) begin
                    r_rem <= w_trial[XLEN-1:0];
                    r_quo <= {r_quo[XLEN-2:0], 1'b1};
                end else begin
                    r_rem <= w_shift[XLEN-1:0];
                    r_quo <= {r_quo[XLEN-2:0], 1'b0};
                end
                r_count <= r_count + c_cnt_w'(1);
                if (r_count == c_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign w_prod_fix = r_neg_q ? -r_prod : r_prod;
    assign w_quo_fix  = r_neg_q ? -r_quo  : r_quo;
    assign w_rem_fix  = r_neg_r ? -r_rem  : r_rem;

    always_comb begin
        result = '0;
        if (!r_op[2]) begin
            result = r_op[0] ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0];
        end else begin
            result = r_op[1] ? w_rem_fix : w_quo_fix;
        end
    end

    assign done = r_done;

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module   : seq_alu
// Brief    : Valid/ready sequential ALU; single-cycle ops plus optional
//            iterative multiply/divide enabled by macro SEQ_ALU_MULDIV_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int XLEN = c_default_xlen
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_control,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            overflow
);

    localparam int c_shw = $clog2(XLEN);

    state_e            r_state;
    state_e            w_next_state;
    logic [XLEN-1:0]   r_result;
    logic              r_zero;
    logic              r_overflow;

    alu_op_e           w_op;
    logic              w_accept;
    logic              w_fast;
    logic [XLEN-1:0]   w_alu_result;
    logic              w_alu_ovf;
    logic [XLEN-1:0]   w_sum;
    logic [XLEN-1:0]   w_diff;
    logic [c_shw-1:0]  w_shamt;
    logic              w_md_done;
    logic [XLEN-1:0]   w_md_result;

    assign w_op     = alu_op_e'(alu_control);
    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_valid && in_ready;
    assign w_sum    = a + b;
    assign w_diff   = a - b;
    assign w_shamt  = b[c_shw-1:0];

`ifdef SEQ_ALU_MULDIV_EN
    localparam logic [XLEN-1:0] c_min = {1'b1, {(XLEN-1){1'b0}}};

    logic w_div_ovf;
    logic w_start;

    assign w_div_ovf = !alu_control[0] && (a == c_min) && (b == '1);
    assign w_start   = w_accept && !w_fast;

    seq_alu_muldiv #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_start),
        .op     (alu_control[2:0]),
        .a      (a),
        .b      (b),
        .done   (w_md_done),
        .result (w_md_result)
    );
`else
    assign w_md_done   = 1'b0;
    assign w_md_result = '0;
`endif

    // Results of single-cycle ops are formed from the live inputs and
    // registered on the accept edge, which is what captures the operands.
    always_comb begin
        w_alu_result = '0;
        w_alu_ovf    = 1'b0;
        w_fast       = 1'b1;
        case (w_op)
            OP_ADD: begin
                w_alu_result = w_sum;
                w_alu_ovf    = (a[XLEN-1] == b[XLEN-1]) && (w_sum[XLEN-1] != a[XLEN-1]);
            end
            OP_SUB: begin
                w_alu_result = w_diff;
                w_alu_ovf    = (a[XLEN-1] != b[XLEN-1]) && (w_diff[XLEN-1] != a[XLEN-1]);
            end
            OP_AND:  w_alu_result = a & b;
            OP_OR:   w_alu_result = a | b;
            OP_XOR:  w_alu_result = a ^ b;
            OP_SLL:  w_alu_result = a << w_shamt;
            OP_SRL:  w_alu_result = a >> w_shamt;
            OP_SRA:  w_alu_result = $signed(a) >>> w_shamt;
            OP_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, (a < b)};
`ifdef SEQ_ALU_MULDIV_EN
            OP_MUL, OP_MULH: w_fast = 1'b0;
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                if (b == '0) begin
                    w_alu_result = alu_control[1] ? a : '1;
                end else if (w_div_ovf) begin
                    w_alu_result = alu_control[1] ? '0 : c_min;
                    w_alu_ovf    = 1'b1;
                end else begin
                    w_fast = 1'b0;
                end
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_next_state = w_fast ? ST_DONE : ST_CALC;
            ST_CALC: if (w_md_done) w_next_state = ST_DONE;
            ST_DONE: if (out_ready) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept && w_fast) begin
                r_result   <= w_alu_result;
                r_zero     <= (w_alu_result == '0);
                r_overflow <= w_alu_ovf;
            end else if ((r_state == ST_CALC) && w_md_done) begin
                r_result   <= w_md_result;
                r_zero     <= (w_md_result == '0);
                r_overflow <= 1'b0;
            end
        end
    end

    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning operand/result width (legal values 8..64, even).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have ports a, b  input  XLEN each  operands.
REQ-007 SHALL have port alu_control  input  4  opcode.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port result  output  XLEN  operation result.
REQ-011 SHALL have ports zero, overflow  output  1 each  flags qualified by out_valid.

Function
REQ-012 Opcodes SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 MUL, 1011 MULH, 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
REQ-013 FSM states SHALL be IDLE, CALC, DONE; in_ready = 1 only in IDLE.
REQ-014 Accept = in_valid && in_ready; a, b, alu_control SHALL be captured on accept and later input changes ignored.
REQ-015 Opcodes 0000-1001 SHALL go IDLE->DONE; out_valid asserted the cycle after accept (latency 1).
REQ-016 MUL/MULH SHALL iterate shift-add, one bit per cycle: IDLE->CALC for XLEN cycles ->DONE; out_valid at accept+XLEN+1.
REQ-017 DIV/DIVU/REM/REMU SHALL iterate restoring division, one bit per cycle, same latency as REQ-016; signed ops on magnitudes with sign fix-up.
REQ-018 Divide by zero SHALL skip CALC (latency 1): quotient all-ones, remainder = a, overflow = 0.
REQ-019 Signed DIV/REM of most-negative by -1 SHALL skip CALC: quotient = most-negative, remainder = 0, overflow = 1.
REQ-020 Shifts SHALL use b[log2(XLEN)-1:0] only; SLT/SLTU return 0 or 1 zero-extended.
REQ-021 overflow SHALL be signed overflow for ADD/SUB, REQ-019 case only for DIV, 0 otherwise; MUL/MULH overflow = 0.
REQ-022 zero SHALL equal (result == 0) for every opcode.
REQ-023 In DONE, result/zero/overflow SHALL hold stable while out_valid && !out_ready; DONE->IDLE on out_ready.
REQ-024 MULH SHALL return upper XLEN bits of signed x signed product; MUL the lower XLEN bits.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, in_ready = 1 after release, out_valid = 0, result = 0, zero = 0, overflow = 0, iteration counter = 0.
REQ-026 Reset during CALC or DONE SHALL abort the operation; no result for it is ever presented.

Configuration
REQ-027 Macro SEQ_ALU_MULDIV_EN defined: opcodes 1010-1111 per REQ-016..019,024.
REQ-028 Macro undefined: no multiply/divide datapath instantiated; opcodes 1010-1111 complete at latency 1 with result = 0, zero = 1, overflow = 0.

Structure
REQ-029 Package seq_alu_pkg SHALL hold opcode localparams/enum, FSM state enum and default XLEN constant.
REQ-030 Iterative multiply/divide datapath SHALL be sub-module seq_alu_muldiv (start/done interface), instantiated only under SEQ_ALU_MULDIV_EN.

Verification (XLEN=64)
REQ-031 ADD a=7FFFFFFFFFFFFFFF, b=1 -> out_valid 1 cycle after accept, result 8000000000000000, zero 0, overflow 1.
REQ-032 SUB a=50, b=50 -> result 0, zero 1, overflow 0; SRA a=8000000000000000, b=63 -> result FFFFFFFFFFFFFFFF.
REQ-033 MUL a=-3, b=5 -> out_valid at accept+65, result FFFFFFFFFFFFFFF1; MULH same -> FFFFFFFFFFFFFFFF.
REQ-034 DIV a=-7, b=2 -> quotient -3; REM -> -1; DIVU a=100, b=0 -> result FFFFFFFFFFFFFFFF at latency 1; DIV 8000000000000000 / -1 -> 8000000000000000, overflow 1.
REQ-035 out_ready held 0 for 5 cycles in DONE -> result/flags stable, in_ready 0; new in_valid with changed a ignored until IDLE.
REQ-036 rst_n pulsed low mid-CALC of DIV -> out_valid 0, in_ready 1 after release, no stale result; next ADD 10+20 -> 30.
